// File: rtl/shift_right_ctrl_pkg.sv
// Shared definitions for the shift controller family: FSM state encoding
// and default datapath dimensions, reused by future ALU controllers.
package shift_right_ctrl_pkg;

    // Default operand width and shift-amount width.
    localparam int DEF_WIDTH = 4;
    localparam int DEF_AW    = 3;

    // Controller states; the numeric encoding is fixed and shared.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right.sv
// One-position logical right shift: the vacated MSB is filled with zero.
module shift_right
    import shift_right_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result
);

    // Pure combinational single-bit shift towards the LSB.
    always_comb begin
        result = {1'b0, data[WIDTH-1:1]};
    end

endmodule

// File: rtl/shift_right_ctrl.sv
// Multi-cycle right-shift controller. A request is latched in IDLE, shifted
// one position per SHIFT cycle, and the result is held in DONE until the
// consumer takes it. Arithmetic mode re-imposes the operand MSB on each step.
module shift_right_ctrl
    import shift_right_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AW-1:0]    req_amt,
    input  logic             req_arith,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    // Count must be able to hold WIDTH itself (the saturated amount).
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] work_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    eff_amt;
    logic             arith;
    logic             accept;

    // Saturate the requested amount at WIDTH: shifting further cannot
    // change the result, and this bounds the number of SHIFT cycles.
    function automatic logic [CW-1:0] clamp_amt(input logic [AW-1:0] amt);
        if (int'(amt) >= WIDTH) begin
            return CW'(WIDTH);
        end
        return CW'(amt);
    endfunction

    assign eff_amt = clamp_amt(req_amt);
    assign accept  = req_valid && req_ready;

    shift_right #(
        .WIDTH (WIDTH)
    ) u_shift_right (
        .data   (work),
        .result (shifted)
    );

    // Apply the fill mode: in arithmetic mode the MSB of the working register
    // never changes, so it still equals the latched operand's MSB.
    always_comb begin
        work_next = shifted;
        if (arith) begin
            work_next[WIDTH-1] = work[WIDTH-1];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = (eff_amt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (count == CW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state alone; handshakes never overlap.
    always_comb begin
        req_ready = (state == ST_IDLE);
        res_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        res_data  = work;
    end

    // Operand capture on accept, then one shift step per SHIFT cycle;
    // req_* inputs are only sampled on accept so in-flight data is protected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            count <= '0;
            arith <= 1'b0;
        end else if (accept) begin
            work  <= req_data;
            count <= eff_amt;
            arith <= req_arith;
        end else if (state == ST_SHIFT) begin
            work  <= work_next;
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_shift_right_ctrl.sv
// Scoreboard bench for shift_right_ctrl: the driver queues the hand-computed
// result and latency for each accepted request, the monitor checks them.
module tb_shift_right_ctrl;

    localparam int WIDTH = 4;
    localparam int AW    = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               acc;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AW-1:0]    req_amt;
    logic             req_arith;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   seen   = 0;

    shift_right_ctrl #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_arith (req_arith),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [AW-1:0] a,
                        input logic ar, input logic [WIDTH-1:0] e, input int lat);
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            check("send_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_arith = ar;
        q.push_back('{data: e, acc: cyc, lat: lat});
        @(posedge clk);
        #1;
        // Scramble the request bus; the in-flight operation must not notice.
        req_valid = 1'b0;
        req_data  = ~d;
        req_amt   = '0;
        req_arith = ~ar;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (q.size() != 0 && g < 60) begin
            @(negedge clk);
            #3;
            g++;
        end
        if (q.size() != 0) begin
            check({name, "_timeout"}, int'(q.size()), 0);
            q.delete();
            seen = 0;
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && res_valid) begin
                check("no_overlap_req_ready", int'(req_ready), 0);
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("res_data", int'(res_data), int'(q[0].data));
                    if (!seen) begin
                        check("latency", cyc - q[0].acc, q[0].lat);
                        seen = 1;
                    end
                    if (res_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        req_amt   = '0;
        req_arith = 1'b0;
        res_ready = 1'b1;
        #1;
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_data",  int'(res_data),  0);
        check("rst_busy",      int'(busy),      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Logical shift by one, then req_ready must return right after.
        send(4'b1101, 3'd1, 1'b0, 4'b0110, 2);
        drain("lsr1");
        @(posedge clk);
        #1;
        check("ready_after_done", int'(req_ready), 1);
        check("idle_after_done",  int'(busy),      0);

        // Arithmetic shifts, zero and saturating amounts, extra patterns.
        send(4'b1101, 3'd2, 1'b1, 4'b1111, 3);
        drain("asr_neg");
        send(4'b0101, 3'd2, 1'b1, 4'b0001, 3);
        drain("asr_pos");
        send(4'b0101, 3'd0, 1'b0, 4'b0101, 1);
        drain("amt0");
        send(4'b1111, 3'd7, 1'b0, 4'b0000, 5);
        drain("lsr_sat");
        send(4'b1000, 3'd7, 1'b1, 4'b1111, 5);
        drain("asr_sat");
        send(4'b1010, 3'd3, 1'b1, 4'b1111, 4);
        drain("asr3");
        send(4'b1010, 3'd4, 1'b0, 4'b0000, 5);
        drain("lsr4");
        send(4'b0110, 3'd2, 1'b0, 4'b0001, 3);
        drain("lsr2");
        send(4'b1001, 3'd1, 1'b1, 4'b1100, 2);
        drain("asr1");
        send(4'b0111, 3'd5, 1'b1, 4'b0000, 5);
        drain("asr_sat_pos");

        // Backpressure: result held, competing request ignored.
        @(negedge clk);
        res_ready = 1'b0;
        send(4'b0010, 3'd1, 1'b0, 4'b0001, 2);
        begin
            int g = 0;
            while (!res_valid && g < 20) begin
                @(negedge clk);
                g++;
            end
        end
        check("bp_reached_done", int'(res_valid), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_data  = 4'b1111;
            req_amt   = 3'd0;
            #1;
            check("bp_hold_valid", int'(res_valid), 1);
            check("bp_hold_data",  int'(res_data),  4'b0001);
            check("bp_no_accept",  int'(req_ready), 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        res_ready = 1'b1;
        drain("bp");
        @(posedge clk);
        #1;
        check("bp_idle_ready", int'(req_ready), 1);
        check("bp_idle_busy",  int'(busy),      0);

        // Reset during the second SHIFT cycle aborts the operation.
        send(4'b1111, 3'd3, 1'b0, 4'b0001, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy",      int'(busy),      0);
        check("abort_res_valid", int'(res_valid), 0);
        check("abort_req_ready", int'(req_ready), 1);
        check("abort_res_data",  int'(res_data),  0);
        q.delete();
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(4'b0000, 3'd1, 1'b0, 4'b0000, 2);
        drain("post_reset");
        send(4'b1011, 3'd1, 1'b0, 4'b0101, 2);
        drain("post_reset2");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_right_ctrl.md
SHIFT_RIGHT_CTRL -- requirements
Module: shift_right_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, data width in bits.
REQ-002 Parameter AW, default 3, shift-amount width in bits.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  a shift request is presented.
REQ-006 req_ready  output  1  the block can accept a request.
REQ-007 req_data  input  WIDTH  operand to shift.
REQ-008 req_amt  input  AW  number of positions to shift right.
REQ-009 req_arith  input  1  fill mode: 1 is arithmetic (MSB replicated), 0 is logical (zero fill).
REQ-010 res_valid  output  1  a result is available.
REQ-011 res_ready  input  1  the consumer accepts the result.
REQ-012 res_data  output  WIDTH  shifted result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE, and res_valid SHALL be 1 only in DONE.
REQ-016 A request is accepted on a clock edge where req_valid and req_ready are both 1: the block latches req_data, req_arith and the count eff_amt = min(req_amt, WIDTH).
REQ-017 On accept, if eff_amt is 0 the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-018 Each SHIFT cycle SHALL shift the working register right by exactly one position and decrement the count.
- The vacated MSB is 0 in logical mode.
- The vacated MSB is the latched operand's MSB in arithmetic mode.
REQ-019 SHIFT SHALL transition to DONE on the edge where the count goes from 1 to 0.
REQ-020 Latency SHALL be eff_amt+1 clock edges from the accept edge to res_valid being asserted.
REQ-021 For req_amt >= WIDTH the result SHALL be all zeros (logical) or all copies of the operand MSB (arithmetic).
REQ-022 In DONE, res_data and res_valid SHALL hold stable until res_ready is 1.
REQ-023 On the edge where res_valid and res_ready are both 1, the FSM SHALL return to IDLE; req_ready rises in the following cycle, with no same-cycle overlap.
REQ-024 Changes on the req_* inputs SHALL be ignored outside IDLE; in-flight operands are never altered.
REQ-025 res_ready asserted outside DONE SHALL have no effect.

Reset
REQ-026 While rst_n is 0, the block SHALL be held in the reset state, asynchronously:
- state IDLE
- working register 0
- count 0
- latched mode 0
REQ-027 During reset the outputs SHALL be req_ready=1, res_valid=0, res_data=0 and busy=0.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation with no result delivered; the first request after release is processed normally.

Structure
REQ-029 The state encoding (IDLE=0, SHIFT=1, DONE=2) and the default WIDTH/AW constants SHALL live in a shared package reused by future ALU controllers.
REQ-030 The one-position logical shift SHALL be a single instance of the existing combinational sub-module shift_right.
REQ-031 The controller SHALL overwrite the MSB of the shift_right output when arithmetic mode is latched.
REQ-032 No other sub-modules SHALL be used.

Verification
REQ-033 Logical shift: 1101, amt 1, arith 0, res_ready held 1 -> res_valid on the 2nd edge after accept with res_data 0110, then req_ready=1 on the next cycle.
REQ-034 Arithmetic shift: 1101, amt 2, arith 1 -> res_data 1111 after 3 edges; also 0101, amt 2, arith 1 -> 0001.
REQ-035 Zero and saturating amounts: 0101, amt 0 -> 0101 after 1 edge; 1111, amt 7, arith 0 -> 0000 after 5 edges (clamped to 4); 1000, amt 7, arith 1 -> 1111.
REQ-036 Backpressure: 0010, amt 1 -> res_data 0001 held with res_valid=1 while res_ready=0 for 3 cycles; a new req_valid with 1111 during that time is not accepted; IDLE is reached after res_ready=1.
REQ-037 Reset mid-operation: 1111, amt 3, rst_n pulled low during the 2nd SHIFT cycle -> immediately busy=0, res_valid=0, req_ready=1; after release, 0000, amt 1 -> 0000 after 2 edges.
